// File: rtl/polar_psum_engine.sv
// polar_psum_engine: on-the-fly polar partial-sum accumulator S = u * F^(kron n_act)
module polar_psum_engine #(
  parameter int N_LOG = 3,
  parameter int P_LOG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            len_cfg,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [(1<<P_LOG)-1:0] u,
  output logic [(1<<N_LOG)-1:0] S,
  output logic [N_LOG-1:0]      idx,
  output logic                  done
);
  localparam int N = 1 << N_LOG;
  localparam int P = 1 << P_LOG;
  localparam int LO = (P_LOG > 1) ? P_LOG : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] n_act, n_clamp;
  logic [N_LOG:0] len, nxt_idx;
  logic [N-1:0] delta;
  logic acc, last;
  assign in_ready = state == ACTIVE;
  assign done = state == DONE;
  assign acc = in_valid && in_ready;
  assign len = (N_LOG+1)'(1) << n_act;
  assign nxt_idx = {1'b0, idx} + (N_LOG+1)'(P);
  assign last = nxt_idx == len;
  assign n_clamp = (len_cfg < 4'(LO)) ? 4'(LO) : (len_cfg > 4'(N_LOG)) ? 4'(N_LOG) : len_cfg;
  // G[i][j] = ((i & j) == j); rows i < L keep every j >= L at zero automatically
  always_comb begin
    delta = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < P; k++)
        delta[j] = delta[j] ^ (u[k] & (((idx + N_LOG'(k)) & N_LOG'(j)) == N_LOG'(j)));
  end
  // next state: start wins over everything except rst
  always_comb begin
    state_nx = IDLE;
    if (start) state_nx = ACTIVE;
    else if (state == ACTIVE) state_nx = (acc && last) ? DONE : ACTIVE;
  end
  // state, partial sums, index and latched length
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      S <= '0;
      idx <= '0;
      n_act <= 4'(N_LOG);
    end else begin
      state <= state_nx;
      if (start) begin
        S <= '0;
        idx <= '0;
        n_act <= n_clamp;
      end else if (acc) begin
        S <= S ^ delta;
        idx <= last ? '0 : nxt_idx[N_LOG-1:0];
      end
    end
  end
endmodule

// File: doc/polar_psum_engine.md
POLAR_PSUM_ENGINE -- requirements
Module: polar_psum_engine

Interface
REQ-001 Parameter N_LOG, default 3, meaning log2 of maximum code length N = 2^N_LOG (legal 2..10).
REQ-002 Parameter P_LOG, default 0, meaning log2 of decoded bits accepted per beat P = 2^P_LOG (legal 0..N_LOG-1).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a new codeword; sampled every cycle.
REQ-006 len_cfg  input  4  log2 of runtime code length n_act; latched only on an accepted start.
REQ-007 in_valid  input  1  beat of decoded bits present on u.
REQ-008 in_ready  output  1  engine can accept a beat this cycle.
REQ-009 u  input  P  decoded bits; u[k] is bit index idx+k of the codeword.
REQ-010 S  output  N  partial-sum vector, registered.
REQ-011 idx  output  N_LOG  index of the next bit to be accepted, registered.
REQ-012 done  output  1  one-cycle pulse, final S valid.

Function
REQ-013 States SHALL be IDLE, ACTIVE, DONE, state-encoded internally.
REQ-014 in_ready SHALL be 1 exactly when state is ACTIVE; a beat is accepted when in_valid and in_ready are both 1.
REQ-015 On start in any state: S SHALL clear to 0, idx to 0, n_act latched, state to ACTIVE next cycle; start has priority over a beat accepted in that same cycle (beat discarded).
REQ-016 n_act SHALL be len_cfg clamped to [max(P_LOG,1), N_LOG]; active length L = 2^n_act.
REQ-017 Generator SHALL be G = F^(kron n_act), F = [[1,0],[1,1]], computed on the fly with no stored matrix: G[i][j] = 1 iff (i AND j) == j, for i,j < L.
REQ-018 Accepted beat: S[j] <= S[j] XOR (XOR over k<P of (u[k] AND G[idx+k][j])) for all j < L, in the cycle following acceptance (latency 1).
REQ-019 S[j] for j >= L SHALL remain 0 for the whole codeword.
REQ-020 Accepted beat SHALL advance idx by P; when idx+P == L the beat is the last: state goes to DONE, idx wraps to 0.
REQ-021 No accepted beat (in_valid low in ACTIVE): S and idx SHALL hold.
REQ-022 DONE SHALL last exactly one cycle with done = 1, then IDLE; done = 0 in all other states.
REQ-023 In IDLE and DONE, S SHALL hold its final value until the next start or rst.
REQ-024 u, in_valid SHALL be ignored outside ACTIVE; len_cfg changes outside an accepted start SHALL have no effect.

Reset
REQ-025 rst SHALL override start and beats: next cycle state IDLE, S = 0, idx = 0, done = 0, in_ready = 0, n_act = N_LOG.
REQ-026 rst asserted mid-codeword SHALL discard all partial sums; no done pulse SHALL follow.

Verification
REQ-027 N_LOG=3, P_LOG=0, len_cfg=3, beats u = 0,0,0,1,0,0,0,0 -> S = 8'h0F, done pulse 1 cycle after 8th beat, idx = 0.
REQ-028 Same config, all eight u = 1 -> S = 8'h80; intermediate after beat u0 only: S = 8'h01.
REQ-029 N_LOG=3, P_LOG=1, len_cfg=3, four beats u = 2'b11 -> S = 8'h80, done after 4th beat; must equal P_LOG=0 result.
REQ-030 N_LOG=3, P_LOG=0, len_cfg=2, u = 1,1,1,1 -> S = 8'h08, done after 4th beat, S[7:4] = 0 throughout.
REQ-031 Backpressure: in_valid low for 3 cycles between beats -> S, idx unchanged during gaps, final S identical to gap-free run; start issued after beat 3 -> S = 0, idx = 0, codeword restarts.
REQ-032 rst after beat 5 of 8 -> S = 0, state IDLE, in_ready = 0, no done; later start runs a full codeword normally.
